// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers digit codes from a scanned 3-digit active-low 7-segment bus
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] an_in,
    input  logic [7:0] sseg_in,
    output logic [4:0] hex2,
    output logic [4:0] hex1,
    output logic [4:0] hex0,
    output logic [2:0] dp_out,
    output logic [2:0] en_out,
    output logic       digit_valid,
    output logic [1:0] digit_idx,
    output logic       frame_valid,
    output logic       err,
    output logic       stale
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [10:0] IDLE_TUPLE = 11'h7FF;

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    state_t        state;
    logic [10:0]   sync1, sync2, t_prev;
    logic [SW-1:0] cnt, cnt_nxt;
    logic [TW-1:0] tcnt;
    logic [2:0]    seen, seen_base, seen_nxt;
    logic          same, blank, evaluate, strobe_ok, known, timeout_hit;
    logic [1:0]    idx;
    logic [4:0]    code;
    logic [2:0]    t_an;
    logic [7:0]    t_sseg;

    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        case (p)
            7'h01: seg_decode = 5'h00;
            7'h4F: seg_decode = 5'h01;
            7'h12: seg_decode = 5'h02;
            7'h06: seg_decode = 5'h03;
            7'h4C: seg_decode = 5'h04;
            7'h24: seg_decode = 5'h05;
            7'h20: seg_decode = 5'h06;
            7'h0F: seg_decode = 5'h07;
            7'h00: seg_decode = 5'h08;
            7'h04: seg_decode = 5'h09;
            7'h08: seg_decode = 5'h0A;
            7'h60: seg_decode = 5'h0B;
            7'h31: seg_decode = 5'h0C;
            7'h42: seg_decode = 5'h0D;
            7'h30: seg_decode = 5'h0E;
            7'h38: seg_decode = 5'h0F;
            7'h41: seg_decode = 5'h10;
            7'h7C: seg_decode = 5'h11;
            7'h7F: seg_decode = 5'h12;
            7'h09: seg_decode = 5'h13;
            default: seg_decode = 5'h1F;
        endcase
    endfunction

    always_comb begin
        t_an      = sync2[10:8];
        t_sseg    = sync2[7:0];
        same      = (sync2 == t_prev);
        blank     = (t_an == 3'b111);
        if (!same)
            cnt_nxt = '0;
        else if (cnt == SW'(SETTLE_CYCLES))
            cnt_nxt = cnt;
        else
            cnt_nxt = cnt + 1'b1;
        evaluate  = (state == SETTLE) && same && (cnt_nxt == SW'(SETTLE_CYCLES - 1));
        strobe_ok = 1'b1;
        idx       = 2'd0;
        case (t_an)
            3'b110:  idx = 2'd0;
            3'b101:  idx = 2'd1;
            3'b011:  idx = 2'd2;
            default: strobe_ok = 1'b0;
        endcase
        code        = seg_decode(t_sseg[6:0]);
        known       = (code != 5'h1F);
        timeout_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1));
        // A capture landing on the timeout edge must see the mask the timeout would have cleared.
        seen_base   = timeout_hit ? 3'b000 : seen;
        seen_nxt    = seen_base | (3'b001 << idx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sync1       <= IDLE_TUPLE;
            sync2       <= IDLE_TUPLE;
            t_prev      <= IDLE_TUPLE;
            cnt         <= '0;
            tcnt        <= '0;
            seen        <= 3'b000;
            hex0        <= 5'h12;
            hex1        <= 5'h12;
            hex2        <= 5'h12;
            dp_out      <= 3'b000;
            en_out      <= 3'b000;
            digit_valid <= 1'b0;
            digit_idx   <= 2'd0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            stale       <= 1'b0;
        end else begin
            sync1       <= {an_in, sseg_in};
            sync2       <= sync1;
            t_prev      <= sync2;
            cnt         <= cnt_nxt;
            digit_valid <= 1'b0;
            frame_valid <= 1'b0;
            err         <= 1'b0;

            if (tcnt != TW'(TIMEOUT_CYCLES))
                tcnt <= tcnt + 1'b1;
            if (timeout_hit) begin
                stale <= 1'b1;
                seen  <= 3'b000;
            end

            case (state)
                IDLE: if (!blank) state <= SETTLE;
                SETTLE: begin
                    if (!same)
                        state <= blank ? IDLE : SETTLE;
                    else if (evaluate)
                        state <= HELD;
                end
                HELD: if (!same) state <= blank ? IDLE : SETTLE;
                default: state <= IDLE;
            endcase

            if (evaluate) begin
                tcnt <= '0;
                if (strobe_ok) begin
                    case (idx)
                        2'd0:    hex0 <= code;
                        2'd1:    hex1 <= code;
                        default: hex2 <= code;
                    endcase
                    dp_out[idx] <= ~t_sseg[7];
                    en_out[idx] <= (t_sseg[6:0] != 7'h7F);
                    digit_idx   <= idx;
                    digit_valid <= 1'b1;
                    err         <= !known;
                    stale       <= 1'b0;
                    if (seen_nxt == 3'b111) begin
                        frame_valid <= 1'b1;
                        seen        <= 3'b000;
                    end else begin
                        seen <= seen_nxt;
                    end
                end else begin
                    err   <= 1'b1;
                    stale <= stale;
                    seen  <= seen;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed vector bench for seg_scan_decoder
module tb_seg_scan_decoder;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] an_in;
    logic [7:0] sseg_in;
    logic [4:0] hex2, hex1, hex0;
    logic [2:0] dp_out, en_out;
    logic       digit_valid, frame_valid, err, stale;
    logic [1:0] digit_idx;

    int total = 0;
    int bad   = 0;

    seg_scan_decoder #(.SETTLE_CYCLES(16), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .reset(reset), .an_in(an_in), .sseg_in(sseg_in),
        .hex2(hex2), .hex1(hex1), .hex0(hex0), .dp_out(dp_out), .en_out(en_out),
        .digit_valid(digit_valid), .digit_idx(digit_idx), .frame_valid(frame_valid),
        .err(err), .stale(stale)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] an;
        logic [7:0] sseg;
        int         dv;
        int         er;
        int         fv;
        logic [1:0] idx;
        logic [4:0] code;
        logic       dp;
        logic       en;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic dwell(input logic [2:0] a, input logic [7:0] s, input int n,
                         output int dvc, output int erc, output int fvc, output int lat,
                         output logic [1:0] ix, output logic [4:0] cd,
                         output logic dpv, output logic env);
        an_in = a; sseg_in = s;
        dvc = 0; erc = 0; fvc = 0; lat = -1;
        ix = 2'd0; cd = 5'h00; dpv = 1'b0; env = 1'b0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (digit_valid) begin
                dvc++;
                if (lat < 0) begin
                    lat = c;
                    ix  = digit_idx;
                    cd  = (ix == 2'd0) ? hex0 : (ix == 2'd1) ? hex1 : hex2;
                    dpv = dp_out[ix];
                    env = en_out[ix];
                end
            end
            if (err) erc++;
            if (frame_valid) fvc++;
        end
    endtask

    task automatic quiet(input logic [2:0] a, input logic [7:0] s, input int n, input string tag);
        int dvc, erc, fvc, lat;
        logic [1:0] ix;
        logic [4:0] cd;
        logic dpv, env;
        dwell(a, s, n, dvc, erc, fvc, lat, ix, cd, dpv, env);
        chk({tag, "_pulses"}, dvc + erc + fvc, 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int dvc, erc, fvc, lat;
        logic [1:0] ix;
        logic [4:0] cd;
        logic dpv, env;
        dwell(v.an, v.sseg, 40, dvc, erc, fvc, lat, ix, cd, dpv, env);
        chk({tag, "_dv"}, dvc, v.dv);
        chk({tag, "_err"}, erc, v.er);
        chk({tag, "_fv"}, fvc, v.fv);
        if (v.dv != 0) begin
            chk({tag, "_lat"}, lat, 18);
            chk({tag, "_idx"}, ix, v.idx);
            chk({tag, "_code"}, cd, v.code);
            chk({tag, "_dp"}, dpv, v.dp);
            chk({tag, "_en"}, env, v.en);
        end
    endtask

    initial begin
        vecs[0] = '{3'b110, 8'h4F, 1, 0, 0, 2'd0, 5'h01, 1'b1, 1'b1};
        vecs[1] = '{3'b110, 8'h81, 1, 0, 0, 2'd0, 5'h00, 1'b0, 1'b1};
        vecs[2] = '{3'b101, 8'hFC, 1, 0, 0, 2'd1, 5'h11, 1'b0, 1'b1};
        vecs[3] = '{3'b011, 8'hFF, 1, 0, 1, 2'd2, 5'h12, 1'b0, 1'b0};
        vecs[4] = '{3'b100, 8'hFF, 0, 1, 0, 2'd0, 5'h00, 1'b0, 1'b0};
        vecs[5] = '{3'b110, 8'hD5, 1, 1, 0, 2'd0, 5'h1F, 1'b0, 1'b1};
        vecs[6] = '{3'b011, 8'hA4, 1, 0, 0, 2'd2, 5'h05, 1'b0, 1'b1};
        vecs[7] = '{3'b101, 8'h00, 1, 0, 1, 2'd1, 5'h08, 1'b1, 1'b1};

        an_in = 3'b111; sseg_in = 8'hFF; reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_hex", {hex2, hex1, hex0}, {5'h12, 5'h12, 5'h12});
        chk("rst_dp_en", {dp_out, en_out}, 6'b0);
        chk("rst_flags", {digit_valid, frame_valid, err, stale, digit_idx}, 6'b0);

        quiet(3'b111, 8'hFF, 100, "idle");
        chk("idle_hex", {hex2, hex1, hex0}, {5'h12, 5'h12, 5'h12});
        chk("idle_en_stale", {en_out, stale}, 4'b0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            if (i == 3) begin
                chk("frame_hex", {hex2, hex1, hex0}, {5'h12, 5'h11, 5'h00});
                chk("frame_en", en_out, 3'b011);
            end
            quiet(3'b111, 8'hFF, 5, $sformatf("blank%0d", i));
        end

        for (int k = 0; k < 20; k++)
            quiet(3'b101, (k % 2 == 1) ? 8'h88 : 8'h89, 10, $sformatf("glitch%0d", k));
        run_vec('{3'b101, 8'h89, 1, 0, 0, 2'd1, 5'h13, 1'b0, 1'b1}, "after_glitch");

        quiet(3'b110, 8'h06, 10, "pre_reset");
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_hex", {hex2, hex1, hex0}, {5'h12, 5'h12, 5'h12});
        chk("midrst_en_dp", {en_out, dp_out, stale}, 7'b0);
        reset = 1'b0;
        run_vec('{3'b110, 8'h06, 1, 0, 0, 2'd0, 5'h03, 1'b1, 1'b1}, "post_reset");

        quiet(3'b111, 8'hFF, 977, "to_wait");
        chk("stale_before", stale, 1'b0);
        quiet(3'b111, 8'hFF, 1, "to_edge");
        chk("stale_after", stale, 1'b1);
        chk("stale_hold_hex0", hex0, 5'h03);
        run_vec('{3'b101, 8'h4C, 1, 0, 0, 2'd1, 5'h04, 1'b1, 1'b1}, "to_cap1");
        chk("stale_cleared", stale, 1'b0);
        quiet(3'b111, 8'hFF, 5, "to_blank1");
        run_vec('{3'b011, 8'h8F, 1, 0, 0, 2'd2, 5'h07, 1'b0, 1'b1}, "to_cap2");
        quiet(3'b111, 8'hFF, 5, "to_blank2");
        run_vec('{3'b110, 8'h80, 1, 0, 1, 2'd0, 5'h08, 1'b0, 1'b1}, "to_cap0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
